// File: rtl/encoder83_pkg.sv
// Shared constants and state encoding for the pending-request 8:3 encoder.
package encoder83_pkg;

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned CODE_W = 3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/prio8.sv
// Highest-index priority selector: bit 7 wins.
// Ports:
//   vec_i    - 8-bit candidate vector
//   idx_c_o  - index of the highest set bit (0 when none set)
//   any_c_o  - at least one bit of vec_i is set
module prio8 (
  input  logic [7:0] vec_i,
  output logic [2:0] idx_c_o,
  output logic       any_c_o
);

  // Ascending scan so the highest set bit is the last to overwrite idx_c_o.
  always_comb begin
    idx_c_o = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (vec_i[i]) idx_c_o = 3'(i);
    end
  end

  assign any_c_o = |vec_i;

endmodule

// File: rtl/encoder83_pend.sv
// Pending-request 8:3 priority encoder with a valid/ack handshake.
// Rising request edges latch into a pending vector; when enabled, the
// highest pending index is presented on code with valid held until ack.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   req      - request lines (level), edge-detected internally
//   sta      - enable, active-high
//   stb, stc - enables, active-low
//   ack      - consumer accepts the presented code
//   code     - index being presented (held in IDLE)
//   valid    - code is valid
//   pending  - registered pending-request vector
//   ovf      - sticky flag: a request arrived while already pending
module encoder83_pend #(
  parameter int unsigned N_REQ  = encoder83_pkg::N_REQ,
  parameter int unsigned CODE_W = encoder83_pkg::CODE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic              sta,
  input  logic              stb,
  input  logic              stc,
  input  logic              ack,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic [N_REQ-1:0]  pending,
  output logic              ovf
);

  import encoder83_pkg::state_e;
  import encoder83_pkg::ST_IDLE;
  import encoder83_pkg::ST_PRESENT;

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [N_REQ-1:0]    req_q;
  logic [N_REQ-1:0]    pending_q, pending_d;
  logic                ovf_q, ovf_d;

  logic [N_REQ-1:0]    rise;
  logic [N_REQ-1:0]    clr_vec;
  logic                en;
  logic [2:0]          top_idx;
  logic                top_any;

  assign en   = sta & ~stb & ~stc;
  assign rise = req & ~req_q;

  // Selection runs on the registered pending vector only.
  prio8 u_prio8 (
    .vec_i   (pending_q),
    .idx_c_o (top_idx),
    .any_c_o (top_any)
  );

  // Next-state, code load and grant clear.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    clr_vec = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (en && top_any) begin
          state_d = ST_PRESENT;
          code_d  = CODE_W'(top_idx);
        end
      end
      ST_PRESENT: begin
        // Dropping enable withdraws the grant; ack is ignored that cycle.
        if (!en) begin
          state_d = ST_IDLE;
        end else if (ack) begin
          state_d = ST_IDLE;
          clr_vec = N_REQ'(1) << code_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new rise overrides a same-cycle clear; only an uncleared repeat is lost.
  always_comb begin
    pending_d = (pending_q & ~clr_vec) | rise;
    ovf_d     = ovf_q | (|(rise & pending_q & ~clr_vec));
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      code_q    <= '0;
      req_q     <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      req_q     <= req;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign valid   = (state_q == ST_PRESENT);
  assign code    = code_q;
  assign pending = pending_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_encoder83_pend.sv
// Directed self-checking bench for encoder83_pend.
module tb_encoder83_pend;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       sta;
  logic       stb;
  logic       stc;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
  logic       ovf;

  int n_cmp;
  int n_err;

  encoder83_pend dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .sta     (sta),
    .stb     (stb),
    .stc     (stc),
    .ack     (ack),
    .code    (code),
    .valid   (valid),
    .pending (pending),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] c,
                         input logic [7:0] p, input logic o);
    chk({tag, ".valid"},   8'(valid),   8'(v));
    chk({tag, ".code"},    8'(code),    8'(c));
    chk({tag, ".pending"}, pending,     p);
    chk({tag, ".ovf"},     8'(ovf),     8'(o));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; req = 8'h00; sta = 1'b1; stb = 1'b0; stc = 1'b0; ack = 1'b0;
    tick(); tick();
    chk_out("reset", 1'b0, 3'd0, 8'h00, 1'b0);
    rst = 1'b0;

    // Single request, ack held high.
    req = 8'h04;
    tick(); chk_out("t1.e1", 1'b0, 3'd0, 8'h04, 1'b0);
    req = 8'h00; ack = 1'b1;
    tick(); chk_out("t1.e2", 1'b1, 3'd2, 8'h04, 1'b0);
    tick(); chk_out("t1.e3", 1'b0, 3'd2, 8'h00, 1'b0);
    ack = 1'b0;

    // Two simultaneous requests: 7 then 0, with a gap between grants.
    req = 8'h81;
    tick(); chk_out("t2.e1", 1'b0, 3'd2, 8'h81, 1'b0);
    req = 8'h00; ack = 1'b1;
    tick(); chk_out("t2.e2", 1'b1, 3'd7, 8'h81, 1'b0);
    tick(); chk_out("t2.e3", 1'b0, 3'd7, 8'h01, 1'b0);
    tick(); chk_out("t2.e4", 1'b1, 3'd0, 8'h01, 1'b0);
    tick(); chk_out("t2.e5", 1'b0, 3'd0, 8'h00, 1'b0);
    ack = 1'b0;

    // Presented code holds while a higher request arrives.
    req = 8'h02;
    tick(); chk_out("t3.e1", 1'b0, 3'd0, 8'h02, 1'b0);
    req = 8'h00;
    tick(); chk_out("t3.e2", 1'b1, 3'd1, 8'h02, 1'b0);
    req = 8'h40;
    tick(); chk_out("t3.e3", 1'b1, 3'd1, 8'h42, 1'b0);
    req = 8'h00;
    tick(); chk_out("t3.e4", 1'b1, 3'd1, 8'h42, 1'b0);
    ack = 1'b1;
    tick(); chk_out("t3.e5", 1'b0, 3'd1, 8'h40, 1'b0);
    tick(); chk_out("t3.e6", 1'b1, 3'd6, 8'h40, 1'b0);
    tick(); chk_out("t3.e7", 1'b0, 3'd6, 8'h00, 1'b0);
    ack = 1'b0;

    // Enable gating; disable in PRESENT withdraws without clearing.
    sta = 1'b0; req = 8'h10;
    tick(); chk_out("t4.e1", 1'b0, 3'd6, 8'h10, 1'b0);
    req = 8'h00;
    tick(); chk_out("t4.e2", 1'b0, 3'd6, 8'h10, 1'b0);
    sta = 1'b1; stb = 1'b1;
    tick(); chk_out("t4.e3", 1'b0, 3'd6, 8'h10, 1'b0);
    stb = 1'b0;
    tick(); chk_out("t4.e4", 1'b1, 3'd4, 8'h10, 1'b0);
    stc = 1'b1; ack = 1'b1;
    tick(); chk_out("t4.e5", 1'b0, 3'd4, 8'h10, 1'b0);
    stc = 1'b0;
    tick(); chk_out("t4.e6", 1'b1, 3'd4, 8'h10, 1'b0);
    tick(); chk_out("t4.e7", 1'b0, 3'd4, 8'h00, 1'b0);
    ack = 1'b0;

    // Repeat rise while pending and unacked -> overflow.
    req = 8'h08;
    tick(); chk_out("t5.e1", 1'b0, 3'd4, 8'h08, 1'b0);
    req = 8'h00;
    tick(); chk_out("t5.e2", 1'b1, 3'd3, 8'h08, 1'b0);
    req = 8'h08;
    tick(); chk_out("t5.e3", 1'b1, 3'd3, 8'h08, 1'b1);
    tick(); chk_out("t5.e4", 1'b1, 3'd3, 8'h08, 1'b1);

    // Async reset between edges; req held high through reset.
    rst = 1'b1;
    #1; chk_out("t5.rst", 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    rst = 1'b0;
    tick(); chk_out("t6.e1", 1'b0, 3'd0, 8'h08, 1'b0);
    req = 8'h00;
    tick(); chk_out("t6.e2", 1'b1, 3'd3, 8'h08, 1'b0);
    // Ack coincides with a new rise on the same line: set wins, no overflow.
    ack = 1'b1; req = 8'h08;
    tick(); chk_out("t6.e3", 1'b0, 3'd3, 8'h08, 1'b0);
    req = 8'h00;
    tick(); chk_out("t6.e4", 1'b1, 3'd3, 8'h08, 1'b0);
    tick(); chk_out("t6.e5", 1'b0, 3'd3, 8'h00, 1'b0);
    ack = 1'b0;

    // Full pending vector with overflow, then reset mid-grant.
    req = 8'hFF;
    tick(); chk_out("t7.e1", 1'b0, 3'd3, 8'hFF, 1'b0);
    req = 8'h00;
    tick(); chk_out("t7.e2", 1'b1, 3'd7, 8'hFF, 1'b0);
    req = 8'hFF;
    tick(); chk_out("t7.e3", 1'b1, 3'd7, 8'hFF, 1'b1);
    #2;
    rst = 1'b1;
    #1; chk_out("t7.rst", 1'b0, 3'd0, 8'h00, 1'b0);
    req = 8'h00;
    tick();
    rst = 1'b0;
    tick(); chk_out("t7.post", 1'b0, 3'd0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
